range_sequencer: RTL and testbench

RANGE_SEQUENCER -- requirements
Module: range_sequencer

---
 rtl/range_sequencer.sv | 174 +++++++++++++++++
 tb/tb_range_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sequencer.sv
// Ultrasonic range sequencer: fires a trigger pulse, times the echo in distance units
// with a BCD accumulator, and reports the result, a timeout, or a saturation flag.
module range_sequencer #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TICK_DIV       = 5800,
  parameter int ECHO_TIMEOUT   = 2500000,
  parameter int HOLDOFF_CYCLES = 6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto_mode,
  input  logic        echo,
  output logic        trig,
  output logic        cnt_ena,
  output logic        busy,
  output logic [11:0] dist_bcd,
  output logic        dist_valid,
  output logic        timeout,
  output logic        overflow
);

  localparam int TW  = $clog2(TRIG_CYCLES + 1);
  localparam int PW  = $clog2(TICK_DIV + 1);
  localparam int TOW = $clog2(ECHO_TIMEOUT + 1);
  localparam int HW  = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t          state;
  logic            echo_s1, echo_s2, echo_d;
  logic [TW-1:0]   trig_cnt;
  logic [PW-1:0]   presc;
  logic [TOW-1:0]  tmo_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [11:0]     acc;

  logic            echo_rise, echo_fall, tick, tmo_expire, acc_sat;
  logic [PW-1:0]   presc_next;
  logic [11:0]     acc_next;

  // Saturating BCD increment: 999 stays 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    echo_rise  = echo_s2 & ~echo_d;
    echo_fall  = ~echo_s2 & echo_d;
    tick       = (presc == PW'(TICK_DIV - 1));
    presc_next = tick ? '0 : presc + PW'(1);
    acc_sat    = (acc == 12'h999);
    acc_next   = tick ? bcd_inc(acc) : acc;
    tmo_expire = (tmo_cnt == TOW'(ECHO_TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      echo_s1    <= 1'b0;
      echo_s2    <= 1'b0;
      echo_d     <= 1'b0;
      trig_cnt   <= '0;
      presc      <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      acc        <= '0;
      trig       <= 1'b0;
      cnt_ena    <= 1'b0;
      busy       <= 1'b0;
      dist_bcd   <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      echo_s1    <= echo;
      echo_s2    <= echo_s1;
      echo_d     <= echo_s2;
      dist_valid <= 1'b0;
      cnt_ena    <= 1'b0;
      case (state)
        IDLE: begin
          if (start || auto_mode) begin
            state    <= TRIG;
            trig     <= 1'b1;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            trig_cnt <= '0;
          end
        end
        TRIG: begin
          if (trig_cnt == TW'(TRIG_CYCLES - 1)) begin
            state   <= WAIT_ECHO;
            trig    <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            trig_cnt <= trig_cnt + TW'(1);
          end
        end
        WAIT_ECHO: begin
          if (tmo_expire) begin
            state    <= HOLDOFF;
            timeout  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TOW'(1);
            if (echo_rise) begin
              state   <= MEASURE;
              presc   <= '0;
              acc     <= '0;
              cnt_ena <= (TICK_DIV == 1);
            end
          end
        end
        MEASURE: begin
          if (tick && acc_sat) overflow <= 1'b1;
          // The fall is checked first so a tick or expiry on the same cycle still yields a result.
          if (echo_fall) begin
            state      <= HOLDOFF;
            dist_bcd   <= acc_next;
            dist_valid <= 1'b1;
            hold_cnt   <= '0;
          end else if (tmo_expire) begin
            state    <= HOLDOFF;
            timeout  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TOW'(1);
            presc   <= presc_next;
            acc     <= acc_next;
            // Registered so it is high exactly in the cycle the prescaler sits at its wrap value.
            cnt_ena <= (presc_next == PW'(TICK_DIV - 1));
          end
        end
        HOLDOFF: begin
          if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          trig  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_sequencer.sv
// Directed bench for range_sequencer: main instance with short timings plus a
// TICK_DIV=1 instance for saturation; dist_bcd results are scoreboarded on dist_valid.
module tb_range_sequencer;

  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, auto_mode = 1'b0, echo = 1'b0;
  logic        trig, cnt_ena, busy, dist_valid, timeout, overflow;
  logic [11:0] dist_bcd;
  logic        start_o = 1'b0, echo_o = 1'b0;
  logic        trig_o, cnt_ena_o, busy_o, dist_valid_o, timeout_o, overflow_o;
  logic [11:0] dist_bcd_o;

  logic [11:0] exp_q[$];
  logic [11:0] exp_q2[$];
  int errors = 0, checks = 0;
  int valid_cnt = 0, ena_cnt = 0, valid_cnt_o = 0, ena_cnt_o = 0;

  range_sequencer #(.TRIG_CYCLES(4), .TICK_DIV(3), .ECHO_TIMEOUT(100), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .auto_mode(auto_mode), .echo(echo),
    .trig(trig), .cnt_ena(cnt_ena), .busy(busy), .dist_bcd(dist_bcd),
    .dist_valid(dist_valid), .timeout(timeout), .overflow(overflow)
  );

  range_sequencer #(.TRIG_CYCLES(4), .TICK_DIV(1), .ECHO_TIMEOUT(5000), .HOLDOFF_CYCLES(HOLD)) dut_ovf (
    .clk(clk), .reset(reset), .start(start_o), .auto_mode(1'b0), .echo(echo_o),
    .trig(trig_o), .cnt_ena(cnt_ena_o), .busy(busy_o), .dist_bcd(dist_bcd_o),
    .dist_valid(dist_valid_o), .timeout(timeout_o), .overflow(overflow_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every dist_valid must match the oldest expected value
  always @(negedge clk) begin
    if (reset) begin
      if (cnt_ena) ena_cnt++;
      if (cnt_ena_o) ena_cnt_o++;
      if (dist_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_valid: got dist_bcd=%h with no expected entry", dist_bcd);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (dist_bcd !== e) begin
            errors++;
            $display("FAIL sb_dist_bcd: got %h expected %h", dist_bcd, e);
          end
        end
      end
      if (dist_valid_o) begin
        valid_cnt_o++;
        checks++;
        if (exp_q2.size() == 0) begin
          errors++;
          $display("FAIL sb_ovf_unexpected_valid: got dist_bcd=%h with no expected entry", dist_bcd_o);
        end else begin
          logic [11:0] e;
          e = exp_q2.pop_front();
          if (dist_bcd_o !== e) begin
            errors++;
            $display("FAIL sb_ovf_dist_bcd: got %h expected %h", dist_bcd_o, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic drive_echo(input int pre, input int len);
    repeat (pre) @(negedge clk);
    echo = 1'b1;
    repeat (len) @(negedge clk);
    echo = 1'b0;
  endtask

  // Leaves the caller on the first negedge with trig low after a trig pulse.
  task automatic wait_trig_fall(output int width, output bit ok);
    width = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (trig) width++;
      else if (width > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({trig, cnt_ena, busy, dist_valid, timeout, overflow, dist_bcd} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {trig, cnt_ena, busy, dist_valid, timeout, overflow, dist_bcd});
    end
    checks++;
    if ({trig_o, cnt_ena_o, busy_o, dist_valid_o, timeout_o, overflow_o, dist_bcd_o} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs_ovf: got %h expected 0",
               {trig_o, cnt_ena_o, busy_o, dist_valid_o, timeout_o, overflow_o, dist_bcd_o});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({trig, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got trig/busy=%b expected 00", {trig, busy});
    end
  endtask

  task automatic test_single();
    int w, v0;
    bit ok;
    ena_cnt = 0;
    v0 = valid_cnt;
    pulse_start();
    wait_trig_fall(w, ok);
    checks++;
    if (!ok || w != 4) begin
      errors++;
      $display("FAIL single_trig_width: got %0d expected 4", w);
    end
    exp_q.push_back(12'h010);
    drive_echo(4, 30);
    wait_idle(60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_idle: got busy=%b expected 0", busy);
    end
    checks++;
    if (ena_cnt != 10) begin
      errors++;
      $display("FAIL single_cnt_ena: got %0d expected 10", ena_cnt);
    end
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    checks++;
    if ({timeout, overflow, dist_bcd} !== {2'b00, 12'h010}) begin
      errors++;
      $display("FAIL single_result: got %h expected %h", {timeout, overflow, dist_bcd}, {2'b00, 12'h010});
    end
  endtask

  task automatic test_timeout();
    int w, cnt, v0;
    bit ok;
    v0 = valid_cnt;
    pulse_start();
    wait_trig_fall(w, ok);
    cnt = 1;
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (timeout) begin
        ok = 1'b1;
        break;
      end
      cnt++;
    end
    checks++;
    if (!ok || cnt != 100) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d expected 100 (seen=%0b)", cnt, ok);
    end
    wait_idle(40, ok);
    checks++;
    if ({ok, timeout, dist_bcd} !== {2'b11, 12'h010} || valid_cnt != v0) begin
      errors++;
      $display("FAIL timeout_hold: got idle/timeout/dist=%h valid=%0d expected %h valid=0",
               {ok, timeout, dist_bcd}, valid_cnt - v0, {2'b11, 12'h010});
    end
  endtask

  task automatic test_echo_stuck();
    int w, v0;
    bit ok;
    v0 = valid_cnt;
    @(negedge clk) echo = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start();
    checks++;
    if ({trig, timeout} !== 2'b10) begin
      errors++;
      $display("FAIL stuck_timeout_cleared: got trig/timeout=%b expected 10", {trig, timeout});
    end
    wait_trig_fall(w, ok);
    wait_idle(200, ok);
    checks++;
    if ({ok, timeout, dist_bcd} !== {2'b11, 12'h010} || valid_cnt != v0) begin
      errors++;
      $display("FAIL stuck_no_measure: got idle/timeout/dist=%h valid=%0d expected %h valid=0",
               {ok, timeout, dist_bcd}, valid_cnt - v0, {2'b11, 12'h010});
    end
    echo = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Echo falls on the very cycle the timeout counter expires: the result must stand.
  task automatic test_fall_at_expiry();
    int w;
    bit ok;
    ena_cnt = 0;
    pulse_start();
    wait_trig_fall(w, ok);
    exp_q.push_back(12'h031);
    drive_echo(4, 93);
    wait_idle(60, ok);
    checks++;
    if ({timeout, dist_bcd} !== {1'b0, 12'h031} || ena_cnt != 31) begin
      errors++;
      $display("FAIL expiry_race: got timeout/dist=%h ticks=%0d expected %h ticks=31",
               {timeout, dist_bcd}, ena_cnt, {1'b0, 12'h031});
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int seen;
    ena_cnt_o = 0;
    @(negedge clk) start_o = 1'b1;
    @(negedge clk) start_o = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!trig_o) break;
      seen++;
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL ovf_trig_width: got %0d expected 3 after first sample", seen);
    end
    exp_q2.push_back(12'h999);
    repeat (2) @(negedge clk);
    echo_o = 1'b1;
    repeat (1200) @(negedge clk);
    echo_o = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if ({ok, overflow_o, timeout_o, dist_bcd_o} !== {3'b110, 12'h999}) begin
      errors++;
      $display("FAIL ovf_result: got %h expected %h", {ok, overflow_o, timeout_o, dist_bcd_o}, {3'b110, 12'h999});
    end
    checks++;
    if (valid_cnt_o != 1 || ena_cnt_o != 1200) begin
      errors++;
      $display("FAIL ovf_counts: got valid=%0d ticks=%0d expected valid=1 ticks=1200", valid_cnt_o, ena_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int w, idx, vidx, bcnt, v0;
    bit ok;
    ena_cnt = 0;
    v0 = valid_cnt;
    @(negedge clk) auto_mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_trig_fall(w, ok);
      checks++;
      if (!ok || w != 4) begin
        errors++;
        $display("FAIL b2b_trig_width round %0d: got %0d expected 4", r, w);
      end
      exp_q.push_back(12'h003);
      start = (r != 2);
      drive_echo(3, 9);
      if (r == 2) begin
        start = 1'b0;
        auto_mode = 1'b0;
        wait_idle(60, ok);
      end else begin
        idx = 0;
        vidx = -100;
        bcnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          idx++;
          if (dist_valid) vidx = idx;
          if (!busy) bcnt++;
          if (trig) begin
            ok = 1'b1;
            break;
          end
          start = ~start;
        end
        start = 1'b0;
        checks++;
        if (!ok || idx - vidx != HOLD + 1 || bcnt != 1) begin
          errors++;
          $display("FAIL b2b_gap round %0d: got valid_to_trig=%0d idle=%0d expected %0d and 1",
                   r, idx - vidx, bcnt, HOLD + 1);
        end
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, dist_bcd} !== {1'b0, 12'h003} || valid_cnt - v0 != 3 || ena_cnt != 9) begin
      errors++;
      $display("FAIL b2b_final: got busy/dist=%h valid=%0d ticks=%0d expected %h valid=3 ticks=9",
               {busy, dist_bcd}, valid_cnt - v0, ena_cnt, {1'b0, 12'h003});
    end
  endtask

  task automatic test_reset_mid_measure();
    int w, v0;
    bit ok;
    v0 = valid_cnt;
    pulse_start();
    wait_trig_fall(w, ok);
    repeat (3) @(negedge clk);
    echo = 1'b1;
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({trig, cnt_ena, busy, dist_valid, timeout, overflow, dist_bcd} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset_mid: got %h expected 0",
               {trig, cnt_ena, busy, dist_valid, timeout, overflow, dist_bcd});
    end
    @(negedge clk) echo = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if (trig !== 1'b1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL resume_after_reset: got trig=%b valid=%0d expected trig=1 valid=0", trig, valid_cnt - v0);
    end
    ena_cnt = 0;
    wait_trig_fall(w, ok);
    exp_q.push_back(12'h010);
    drive_echo(4, 30);
    wait_idle(60, ok);
    checks++;
    if ({ok, timeout, dist_bcd} !== {2'b10, 12'h010} || ena_cnt != 10) begin
      errors++;
      $display("FAIL post_reset_measure: got %h ticks=%0d expected %h ticks=10",
               {ok, timeout, dist_bcd}, ena_cnt, {2'b10, 12'h010});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_echo_stuck();
    test_fall_at_expiry();
    test_overflow();
    test_back_to_back();
    test_reset_mid_measure();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", exp_q.size(), exp_q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
